// File: rtl/nios_system_pio_pkg.sv
// nios_system_pio_pkg: shared register map and pulse FSM encoding for the LED PIO.
package nios_system_pio_pkg;
    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_LEN  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_SET  = 3'd4;
    localparam logic [2:0] ADDR_CLR  = 3'd5;
    typedef enum logic {IDLE, PULSE} pulse_state_e;
endpackage

// File: rtl/nios_system_led_pio_if.sv
// nios_system_led_pio_if: Avalon-MM slave bus for the LED PIO.
//   address[2:0], chipselect, write_n, writedata[31:0] : master -> slave
//   readdata[31:0]                                     : slave -> master, 1-cycle latency
interface nios_system_led_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_system_pulse_timer.sv
// nios_system_pulse_timer: one-shot pulse FSM holding busy for len cycles after a trigger.
//   clk, reset_n : clock, asynchronous active-low reset
//   trigger      : start/restart the pulse with the current len
//   len          : pulse length in cycles (0 = no pulse, aborts a running one)
//   busy         : high while the pulse runs
//   done         : one-cycle flag after the pulse leaves PULSE
module nios_system_pulse_timer
    import nios_system_pio_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 trigger,
    input  logic [CNT_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done
);
    pulse_state_e         state;
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt_q <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (trigger) begin
                cnt_q <= len;
                state <= (len != '0) ? PULSE : IDLE;
                done  <= (state == PULSE) && (len == '0);
            end else if (state == PULSE) begin
                // cnt_q stays >= 1 in PULSE; the guard keeps it from ever wrapping
                if (cnt_q != '0)
                    cnt_q <= cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == PULSE);
endmodule

// File: rtl/nios_system_led_pio.sv
// nios_system_led_pio: LED output port with set/clear writes and a timed XOR pulse mask.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (DATA, PULSE_LEN, PULSE_MASK, OUTSET, OUTCLR)
//   out_port     : data register XOR mask while a pulse runs
//   pulse_busy   : high while a pulse runs
module nios_system_led_pio
    import nios_system_pio_pkg::*;
#(
    parameter int                  DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                  CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    nios_system_led_pio_if.slave  bus,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  pulse_busy
);
    logic                  wr;
    logic                  trigger;
    logic                  done;
    logic                  unused_bits;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] mask_q;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [31:0]           rd_mux;

    assign wr          = bus.chipselect & ~bus.write_n;
    assign wd          = bus.writedata[DATA_WIDTH-1:0];
    assign trigger     = wr && (bus.address == ADDR_MASK);
    assign unused_bits = ^{bus.writedata, done};

    nios_system_pulse_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .trigger (trigger),
        .len     (len_q),
        .busy    (pulse_busy),
        .done    (done)
    );

    // Bit 31 of the mask readback reports busy; DATA_WIDTH <= 31 keeps it free
    always_comb begin
        rd_mux = (bus.address == ADDR_DATA) ? 32'(data_q) :
                 (bus.address == ADDR_LEN)  ? 32'(len_q)  :
                 (bus.address == ADDR_MASK) ? {pulse_busy, 31'(mask_q)} : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q       <= RESET_VALUE;
            len_q        <= '0;
            mask_q       <= '0;
            bus.readdata <= '0;
        end else begin
            if (wr)
                data_q <= (bus.address == ADDR_DATA) ? wd :
                          (bus.address == ADDR_SET)  ? data_q | wd :
                          (bus.address == ADDR_CLR)  ? data_q & ~wd : data_q;
            if (wr && bus.address == ADDR_LEN)
                len_q <= bus.writedata[CNT_WIDTH-1:0];
            if (trigger)
                mask_q <= wd;
            bus.readdata <= rd_mux;
        end
    end

    assign out_port = data_q ^ (pulse_busy ? mask_q : '0);
endmodule
